qe_m_feeder: RTL and testbench

Operand sequencer that drives the QE_M input interface (the transmitter end of the interface QE_M receives on). It accepts operand commands from an upstream ready/valid port and buffers them in a FIFO. It then issues one operand set per cycle on the QE_M valid_in/last_input/mode/in_a..in_x bus, framing MAC bursts correctly. It guarantees `mode` stays stable through an open MAC burst and closes malformed bursts with a neutral zero term.

---
 rtl/qe_m_feeder.sv | 220 ++++++++++++++++++++++
 tb/tb_qe_m_feeder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/qe_m_feeder.sv
// Operand sequencer feeding the QE_M input bus: buffers upstream commands in a FIFO and frames MAC bursts.
// Optional: define QE_FEED_TIMEOUT_EN to auto-close a MAC burst left idle for TIMEOUT cycles.
module qe_m_feeder #(
    parameter int DEPTH   = 8,
    parameter int LVL_W   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_mode,
    input  logic             cmd_last,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    input  logic [7:0]       cmd_c,
    input  logic [7:0]       cmd_x,
    input  logic             feed_en,
    output logic             qe_valid_in,
    output logic             qe_last_input,
    output logic             qe_mode,
    output logic [7:0]       qe_a,
    output logic [7:0]       qe_b,
    output logic [7:0]       qe_c,
    output logic [7:0]       qe_x,
    output logic             busy,
    output logic             proto_err,
    output logic [LVL_W-1:0] fifo_level
);

    localparam int IDX_W = LVL_W - 1;

    typedef struct packed {
        logic       mode;
        logic       last;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic [7:0] x;
    } cmd_t;

    typedef enum logic {
        IDLE,
        MAC_OPEN
    } state_t;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("qe_m_feeder: DEPTH must be a power of 2 and at least 2");
    end
    if ((1 << (LVL_W - 1)) != DEPTH) begin : g_bad_lvl_w
        $error("qe_m_feeder: LVL_W must equal log2(DEPTH)+1");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("qe_m_feeder: TIMEOUT must be at least 1");
    end

    // ------------------------------------------------------------------
    // Command FIFO: pointers carry one extra wrap bit so level = wr - rd.
    // ------------------------------------------------------------------
    cmd_t             mem [DEPTH];
    logic [LVL_W-1:0] wr_ptr;
    logic [LVL_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    logic             full;
    logic             empty;
    logic             ready_q;
    logic             push;
    logic             do_pop;
    cmd_t             head;
    cmd_t             cmd_in;

    assign level      = wr_ptr - rd_ptr;
    assign full       = (level == LVL_W'(DEPTH));
    assign empty      = (level == '0);
    assign cmd_ready  = ready_q && !full;
    assign push       = cmd_valid && cmd_ready;
    assign head       = mem[rd_ptr[IDX_W-1:0]];
    assign fifo_level = level;

    assign cmd_in = '{mode: cmd_mode, last: cmd_last,
                      a: cmd_a, b: cmd_b, c: cmd_c, x: cmd_x};

    // ready_q holds cmd_ready low while reset is asserted and releases it on the first edge after.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_q <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
        end else begin
            ready_q <= 1'b1;
            if (push)   wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage array is deliberately not reset; emptiness is tracked solely by the pointers.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[IDX_W-1:0]] <= cmd_in;
    end

    // ------------------------------------------------------------------
    // Burst FSM
    // ------------------------------------------------------------------
    state_t state;
    state_t nxt_state;
    logic   do_close;
    logic   proto_set;

`ifdef QE_FEED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] idle_cnt;
    logic             timeout_hit;

    assign timeout_hit = (idle_cnt >= CNT_W'(TIMEOUT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_cnt <= '0;
        end else if (state != MAC_OPEN || do_pop || do_close) begin
            idle_cnt <= '0;
        end else if (!timeout_hit) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    logic timeout_hit;
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nxt_state;
    end

    always_comb begin
        nxt_state = state;
        case (state)
            IDLE:     if (do_pop && head.mode && !head.last) nxt_state = MAC_OPEN;
            MAC_OPEN: if (do_close || (do_pop && head.last)) nxt_state = IDLE;
            default:  nxt_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Issue decision and next bus values
    // ------------------------------------------------------------------
    logic       nxt_valid;
    logic       nxt_last;
    logic       nxt_mode;
    logic [7:0] nxt_a;
    logic [7:0] nxt_b;
    logic [7:0] nxt_c;
    logic [7:0] nxt_x;

    // NOTE: every signal gets a default at the top so no path leaves one unassigned (no latches).
    always_comb begin
        do_pop    = 1'b0;
        do_close  = 1'b0;
        proto_set = 1'b0;
        nxt_valid = 1'b0;
        nxt_last  = 1'b0;
        nxt_mode  = qe_mode;
        nxt_a     = '0;
        nxt_b     = '0;
        nxt_c     = '0;
        nxt_x     = '0;

        if (feed_en && !empty) begin
            // A polynomial entry cannot enter an open burst: close it first, keep the entry queued.
            if (state == MAC_OPEN && !head.mode) begin
                do_close  = 1'b1;
                proto_set = 1'b1;
            end else begin
                do_pop = 1'b1;
            end
        end else if (feed_en && state == MAC_OPEN && timeout_hit) begin
            do_close = 1'b1;
        end

        if (do_pop) begin
            nxt_valid = 1'b1;
            nxt_last  = head.mode & head.last;
            nxt_mode  = head.mode;
            nxt_a     = head.a;
            nxt_b     = head.b;
            nxt_c     = head.c;
            nxt_x     = head.x;
        end else if (do_close) begin
            nxt_valid = 1'b1;
            nxt_last  = 1'b1;
            nxt_mode  = 1'b1;
        end
    end

    // NOTE: registered state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            qe_valid_in   <= 1'b0;
            qe_last_input <= 1'b0;
            qe_mode       <= 1'b0;
            qe_a          <= '0;
            qe_b          <= '0;
            qe_c          <= '0;
            qe_x          <= '0;
            proto_err     <= 1'b0;
        end else begin
            qe_valid_in   <= nxt_valid;
            qe_last_input <= nxt_last;
            qe_mode       <= nxt_mode;
            qe_a          <= nxt_a;
            qe_b          <= nxt_b;
            qe_c          <= nxt_c;
            qe_x          <= nxt_x;
            if (proto_set) proto_err <= 1'b1;
        end
    end

    assign busy = !empty || (state == MAC_OPEN);

endmodule

// File: tb/tb_qe_m_feeder.sv
// Directed bench for qe_m_feeder: poly issue, MAC bursts, bubbles, forced close, backpressure, reset mid-burst.
module tb_qe_m_feeder;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_mode;
    logic       cmd_last;
    logic [7:0] cmd_a, cmd_b, cmd_c, cmd_x;
    logic       feed_en;
    logic       qe_valid_in;
    logic       qe_last_input;
    logic       qe_mode;
    logic [7:0] qe_a, qe_b, qe_c, qe_x;
    logic       busy;
    logic       proto_err;
    logic [3:0] fifo_level;

    int tests = 0;
    int fails = 0;

    qe_m_feeder #(.DEPTH(8), .LVL_W(4), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode), .cmd_last(cmd_last),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_c(cmd_c), .cmd_x(cmd_x),
        .feed_en(feed_en),
        .qe_valid_in(qe_valid_in), .qe_last_input(qe_last_input), .qe_mode(qe_mode),
        .qe_a(qe_a), .qe_b(qe_b), .qe_c(qe_c), .qe_x(qe_x),
        .busy(busy), .proto_err(proto_err), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic m, input logic l, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] c, input logic [7:0] x);
        cmd_valid = 1'b1;
        cmd_mode  = m;
        cmd_last  = l;
        cmd_a = a; cmd_b = b; cmd_c = c; cmd_x = x;
    endtask

    task automatic check_bus(input string tag, input logic v, input logic l, input logic m,
                             input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] x);
        check({tag, ".valid"}, qe_valid_in, v);
        check({tag, ".last"},  qe_last_input, l);
        check({tag, ".mode"},  qe_mode, m);
        check({tag, ".a"}, qe_a, a);
        check({tag, ".b"}, qe_b, b);
        check({tag, ".c"}, qe_c, c);
        check({tag, ".x"}, qe_x, x);
    endtask

    initial begin
        reset = 1'b0; cmd_valid = 1'b0; cmd_mode = 1'b0; cmd_last = 1'b0;
        cmd_a = '0; cmd_b = '0; cmd_c = '0; cmd_x = '0; feed_en = 1'b1;

        // Reset state
        #2;
        check_bus("rst", 0, 0, 0, 0, 0, 0, 0);
        check("rst.level", fifo_level, 0);
        check("rst.ready", cmd_ready, 0);
        check("rst.busy", busy, 0);
        check("rst.perr", proto_err, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        step();
        check("post_rst.ready", cmd_ready, 1);

        // Polynomial entry: one-cycle latency
        set_cmd(0, 0, 100, 5, 25, 8);
        step();
        cmd_valid = 1'b0;
        check("poly.k.valid", qe_valid_in, 0);
        check("poly.k.level", fifo_level, 1);
        check("poly.k.busy", busy, 1);
        step();
        check_bus("poly.k1", 1, 0, 0, 100, 5, 25, 8);
        check("poly.k1.level", fifo_level, 0);
        step();
        check_bus("poly.k2", 0, 0, 0, 0, 0, 0, 0);

        // Back-to-back MAC burst
        set_cmd(1, 0, 100, 0, 0, 8);
        step();
        check("mac.k.valid", qe_valid_in, 0);
        set_cmd(1, 0, 20, 0, 0, 3);
        step();
        check_bus("mac.t1", 1, 0, 1, 100, 0, 0, 8);
        check("mac.t1.level", fifo_level, 1);
        set_cmd(1, 1, 1, 0, 0, 2);
        step();
        cmd_valid = 1'b0;
        check_bus("mac.t2", 1, 0, 1, 20, 0, 0, 3);
        check("mac.t2.level", fifo_level, 1);
        check("mac.t2.busy", busy, 1);
        step();
        check_bus("mac.t3", 1, 1, 1, 1, 0, 0, 2);
        check("mac.t3.busy", busy, 0);
        step();
        check_bus("mac.after", 0, 0, 1, 0, 0, 0, 0);

        // MAC burst with a 3-cycle upstream gap
        set_cmd(1, 0, 100, 0, 0, 8);
        step();
        set_cmd(1, 0, 20, 0, 0, 3);
        step();
        cmd_valid = 1'b0;
        check_bus("bub.t1", 1, 0, 1, 100, 0, 0, 8);
        step();
        check_bus("bub.t2", 1, 0, 1, 20, 0, 0, 3);
        step();
        check_bus("bub.b1", 0, 0, 1, 0, 0, 0, 0);
        check("bub.b1.busy", busy, 1);
        step();
        check_bus("bub.b2", 0, 0, 1, 0, 0, 0, 0);
        set_cmd(1, 1, 1, 0, 0, 2);
        step();
        cmd_valid = 1'b0;
        check_bus("bub.b3", 0, 0, 1, 0, 0, 0, 0);
        check("bub.b3.perr", proto_err, 0);
        step();
        check_bus("bub.t3", 1, 1, 1, 1, 0, 0, 2);
        check("bub.perr", proto_err, 0);
        check("bub.busy", busy, 0);

        // Polynomial entry arriving inside an open burst forces a close term
        set_cmd(1, 0, 4, 0, 0, 1);
        step();
        set_cmd(0, 0, 9, 9, 9, 9);
        step();
        cmd_valid = 1'b0;
        check_bus("fc.m1", 1, 0, 1, 4, 0, 0, 1);
        check("fc.m1.perr", proto_err, 0);
        step();
        check_bus("fc.close", 1, 1, 1, 0, 0, 0, 0);
        check("fc.close.perr", proto_err, 1);
        check("fc.close.level", fifo_level, 1);
        step();
        check_bus("fc.m0", 1, 0, 0, 9, 9, 9, 9);
        check("fc.m0.busy", busy, 0);
        step();
        check("fc.idle.valid", qe_valid_in, 0);
        check("fc.perr_sticky", proto_err, 1);

        // Backpressure: fill with feed_en low, then drain in order
        feed_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_cmd(0, 0, 8'(i + 1), 0, 0, 8'(i + 1));
            step();
        end
        check("bp.level_full", fifo_level, 8);
        check("bp.ready_full", cmd_ready, 0);
        check("bp.paused.valid", qe_valid_in, 0);
        set_cmd(0, 0, 8'hEE, 0, 0, 8'hEE);
        step();
        cmd_valid = 1'b0;
        check("bp.ninth_rejected", fifo_level, 8);
        feed_en = 1'b1;
        step();
        check_bus("bp.pop0", 1, 0, 0, 1, 0, 0, 1);
        check("bp.pop0.level", fifo_level, 7);
        check("bp.pop0.ready", cmd_ready, 1);
        for (int i = 1; i < 8; i++) begin
            step();
            check("bp.pop.valid", qe_valid_in, 1);
            check("bp.pop.a", qe_a, 32'(i + 1));
        end
        check("bp.drained", fifo_level, 0);
        step();
        check("bp.after.valid", qe_valid_in, 0);

        // Reset while a burst is open with three entries queued
        set_cmd(1, 0, 5, 0, 0, 5);
        step();
        cmd_valid = 1'b0;
        step();
        check_bus("rm.t0", 1, 0, 1, 5, 0, 0, 5);
        feed_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_cmd(1, 0, 8'(6 + i), 0, 0, 1);
            step();
        end
        cmd_valid = 1'b0;
        check("rm.level", fifo_level, 3);
        check("rm.busy", busy, 1);
        check("rm.mode_held", qe_mode, 1);
        reset = 1'b0;
        #1;
        check_bus("rm.async", 0, 0, 0, 0, 0, 0, 0);
        check("rm.async.level", fifo_level, 0);
        check("rm.async.busy", busy, 0);
        check("rm.async.perr", proto_err, 0);
        check("rm.async.ready", cmd_ready, 0);
        step();
        step();
        feed_en = 1'b1;
        reset = 1'b1;
        step();
        check("rm.rel.ready", cmd_ready, 1);
        check("rm.rel.valid", qe_valid_in, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("rm.noclose.valid", qe_valid_in, 0);
            check("rm.noclose.last", qe_last_input, 0);
            check("rm.noclose.busy", busy, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
